// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: datapath widths and the fetch-queue entry layout.
package mips_pkg;

  localparam int INSTR_W    = 32;
  localparam int BYTE_W     = 8;
  localparam int WORD_BYTES = 4;
  localparam int PC_W       = 32;

  // PC is carried at full architectural width; the fetch unit zero-extends its byte address.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO with occupancy count; accepts push+pop together when full, flush wins over both.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // When full, the slot being written is the one the head vacates at this same edge.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !clr && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (clr || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_prefetch_unit.sv
// Instruction fetch front end: byte-loadable instruction memory, fetch PC and a prefetch queue
// delivering one big-endian word per cycle to the decoder.
module instr_prefetch_unit
  import mips_pkg::*;
#(
  parameter int              MEM_BYTES = 512,
  parameter int              ADDR_W    = $clog2(MEM_BYTES),
  parameter int              QDEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic                        load_en,
  input  logic [ADDR_W-1:0]           load_addr,
  input  logic [BYTE_W-1:0]           load_data,
  input  logic                        redirect_valid,
  input  logic [ADDR_W-1:0]           redirect_pc,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [INSTR_W-1:0]          out_instr,
  output logic [ADDR_W-1:0]           out_pc,
  output logic [$clog2(QDEPTH+1)-1:0] q_count
);

  logic [BYTE_W-1:0] mem [MEM_BYTES];
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] redirect_target;
  logic [INSTR_W-1:0] fetch_word;
  fetch_entry_t      entry_in;
  fetch_entry_t      head;
  logic              q_full;
  logic              q_empty;
  logic              push;
  logic              pop;
  logic              unused_bits;

  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  // Byte offsets wrap through the ADDR_W-wide adders, i.e. modulo MEM_BYTES.
  assign fetch_word = {mem[fetch_pc],
                       mem[fetch_pc + ADDR_W'(1)],
                       mem[fetch_pc + ADDR_W'(2)],
                       mem[fetch_pc + ADDR_W'(3)]};

  always_comb begin
    entry_in       = '0;
    entry_in.pc    = PC_W'(fetch_pc);
    entry_in.instr = fetch_word;
  end

  assign redirect_target = {redirect_pc[ADDR_W-1:2], 2'b00};

  // Handshake: a word transfers on an edge where out_valid && out_ready; out_valid never
  // depends on out_ready, and a redirect suppresses out_valid so nothing transfers that cycle.
  assign out_valid = ~q_empty & ~redirect_valid;
  assign pop       = out_valid & out_ready;
  assign push      = ~redirect_valid & (~q_full | pop);

  always_ff @(posedge clk) begin
    if (clr) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_target;
    end else if (push) begin
      fetch_pc <= fetch_pc + ADDR_W'(WORD_BYTES);
    end
  end

  instr_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (entry_in),
    .dout  (head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  assign out_instr   = q_empty ? '0 : head.instr;
  assign out_pc      = q_empty ? '0 : head.pc[ADDR_W-1:0];
  assign unused_bits = ^{redirect_pc[1:0], head.pc[PC_W-1:ADDR_W]};

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Bench for instr_prefetch_unit: directed vector table, hand sequences for backpressure and
// mid-run reset, then random traffic against a queue-based reference model.
module tb_instr_prefetch_unit;

  localparam int AW = 9;
  localparam int QD = 4;
  localparam int CW = 3;

  logic          clk;
  logic          clr;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [7:0]    load_data;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          out_ready;
  logic          out_valid;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_pc;
  logic [CW-1:0] q_count;

  int total = 0;
  int bad   = 0;

  logic [7:0] img [512];

  typedef struct {
    logic          clr;
    logic          ready;
    logic          redir;
    logic [AW-1:0] rpc;
    logic          exp_valid;
    logic [AW-1:0] exp_pc;
    logic [31:0]   exp_instr;
    logic [CW-1:0] exp_count;
  } vec_t;

  vec_t vecs[$];

  // reference model: expected queue of {pc, instr} plus the fetch address
  logic [AW+31:0] exp_q[$];
  logic [AW-1:0]  m_fpc;

  instr_prefetch_unit #(
    .MEM_BYTES (512),
    .ADDR_W    (AW),
    .QDEPTH    (QD),
    .RESET_PC  ('0)
  ) dut (
    .clk            (clk),
    .clr            (clr),
    .load_en        (load_en),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .q_count        (q_count)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] word_img(input logic [AW-1:0] a);
    return {img[a], img[a + 9'd1], img[a + 9'd2], img[a + 9'd3]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [AW-1:0] a, input logic [7:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    img[a]    = d;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [31:0] w);
    load_byte(a,          w[31:24]);
    load_byte(a + 9'd1,   w[23:16]);
    load_byte(a + 9'd2,   w[15:8]);
    load_byte(a + 9'd3,   w[7:0]);
  endtask

  task automatic add_vec(input logic c, input logic r, input logic rd, input logic [AW-1:0] rp,
                         input logic v, input logic [AW-1:0] p, input logic [31:0] ins,
                         input logic [CW-1:0] n);
    vec_t e;
    e.clr = c; e.ready = r; e.redir = rd; e.rpc = rp;
    e.exp_valid = v; e.exp_pc = p; e.exp_instr = ins; e.exp_count = n;
    vecs.push_back(e);
  endtask

  // one random cycle checked against the model, then the model advances with the same inputs
  task automatic rstep();
    logic          r_clr, r_red, r_rdy, r_ld, m_valid, m_pop, m_push;
    logic [AW-1:0] r_rpc, r_la;
    logic [7:0]    r_ld_d;
    logic [AW+31:0] head;
    logic [31:0]   w;
    r_clr  = ($urandom_range(0, 99) == 0);
    r_red  = ($urandom_range(0, 15) == 0);
    r_rpc  = AW'($urandom_range(0, 511));
    r_rdy  = ($urandom_range(0, 3) != 0);
    r_ld   = ($urandom_range(0, 7) == 0);
    r_la   = AW'($urandom_range(0, 511));
    r_ld_d = 8'($urandom_range(0, 255));
    clr = r_clr; redirect_valid = r_red; redirect_pc = r_rpc; out_ready = r_rdy;
    load_en = r_ld; load_addr = r_la; load_data = r_ld_d;
    #4;
    m_valid = (exp_q.size() > 0) && !r_red;
    head    = (exp_q.size() > 0) ? exp_q[0] : '0;
    chk("rnd_valid", 64'(out_valid), 64'(m_valid));
    chk("rnd_pc",    64'(out_pc),    64'(head[AW+31:32]));
    chk("rnd_instr", 64'(out_instr), 64'(head[31:0]));
    chk("rnd_count", 64'(q_count),   64'(exp_q.size()));
    @(posedge clk);
    w = word_img(m_fpc);
    if (r_clr) begin
      exp_q.delete();
      m_fpc = '0;
    end else if (r_red) begin
      exp_q.delete();
      m_fpc = r_rpc & 9'h1FC;
    end else begin
      m_pop  = m_valid && r_rdy;
      m_push = (exp_q.size() < QD) || m_pop;
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) begin
        exp_q.push_back({m_fpc, w});
        m_fpc = m_fpc + 9'd4;
      end
    end
    if (r_ld) img[r_la] = r_ld_d;
    #1;
  endtask

  initial begin
    int got;
    clr = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    tick();
    tick();

    // program memory while held in reset
    for (int i = 0; i < 512; i++) load_byte(AW'(i), 8'(i * 7 + 3));
    load_word(9'h000, 32'h00000020);
    load_word(9'h004, 32'h8C010004);
    load_word(9'h008, 32'h00221820);

    //       clr rdy red rpc     valid pc      instr                 count
    add_vec(1, 1, 0, 9'h000, 0, 9'h000, 32'h0,              0);
    add_vec(0, 1, 0, 9'h000, 0, 9'h000, 32'h0,              0);
    add_vec(0, 1, 0, 9'h000, 1, 9'h000, 32'h00000020,       1);
    add_vec(0, 1, 0, 9'h000, 1, 9'h004, 32'h8C010004,       1);
    add_vec(0, 1, 0, 9'h000, 1, 9'h008, 32'h00221820,       1);
    add_vec(0, 0, 0, 9'h000, 1, 9'h00C, word_img(9'h00C),   1);
    add_vec(0, 0, 0, 9'h000, 1, 9'h00C, word_img(9'h00C),   2);
    add_vec(0, 1, 1, 9'h0A6, 0, 9'h00C, word_img(9'h00C),   3);
    add_vec(0, 1, 0, 9'h000, 0, 9'h000, 32'h0,              0);
    add_vec(0, 1, 0, 9'h000, 1, 9'h0A4, word_img(9'h0A4),   1);
    add_vec(0, 1, 1, 9'h1FF, 0, 9'h0A8, word_img(9'h0A8),   1);
    add_vec(0, 1, 0, 9'h000, 0, 9'h000, 32'h0,              0);
    add_vec(0, 1, 0, 9'h000, 1, 9'h1FC, word_img(9'h1FC),   1);
    add_vec(0, 1, 0, 9'h000, 1, 9'h000, 32'h00000020,       1);

    foreach (vecs[i]) begin
      clr = vecs[i].clr; out_ready = vecs[i].ready;
      redirect_valid = vecs[i].redir; redirect_pc = vecs[i].rpc;
      #4;
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_pc", i),    64'(out_pc),    64'(vecs[i].exp_pc));
      chk($sformatf("vec%0d_instr", i), 64'(out_instr), 64'(vecs[i].exp_instr));
      chk($sformatf("vec%0d_count", i), 64'(q_count),   64'(vecs[i].exp_count));
      @(posedge clk);
      #1;
    end
    redirect_valid = 1'b0;

    // backpressure from reset: queue saturates, fetch address holds, then drains in order
    clr = 1'b1; out_ready = 1'b0;
    tick();
    clr = 1'b0;
    repeat (10) tick();
    #4;
    chk("bp_count",    64'(q_count),      64'(4));
    chk("bp_fetch_pc", 64'(dut.fetch_pc), 64'(9'h010));
    chk("bp_valid",    64'(out_valid),    64'(1));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      #4;
      if (out_valid) begin
        chk($sformatf("bp_pc%0d", got),    64'(out_pc),    64'(got * 4));
        chk($sformatf("bp_instr%0d", got), 64'(out_instr), 64'(word_img(AW'(got * 4))));
        got++;
      end
      @(posedge clk);
      #1;
    end
    chk("bp_received", 64'(got), 64'(8));

    // reset with three entries queued
    redirect_valid = 1'b1; redirect_pc = 9'h040; out_ready = 1'b0;
    tick();
    redirect_valid = 1'b0;
    repeat (3) tick();
    clr = 1'b1;
    #4;
    chk("rst_pre_count", 64'(q_count), 64'(3));
    @(posedge clk);
    #1;
    clr = 1'b0;
    #4;
    chk("rst_count",    64'(q_count),      64'(0));
    chk("rst_valid",    64'(out_valid),    64'(0));
    chk("rst_fetch_pc", 64'(dut.fetch_pc), 64'(0));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    #4;
    chk("rst_restart_valid", 64'(out_valid), 64'(1));
    chk("rst_restart_pc",    64'(out_pc),    64'(0));
    chk("rst_restart_instr", 64'(out_instr), 64'(32'h00000020));
    @(posedge clk);
    #1;

    // random traffic against the reference model, starting from a clean reset
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_q.delete();
    m_fpc = '0;
    for (int n = 0; n < 3000; n++) rstep();
    clr = 1'b0; load_en = 1'b0; redirect_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
